// File: rtl/gdc_pkg.sv
// Shared definitions for the garage-door controller: synchroniser depth,
// default timing constants and the door-FSM state encoding.
package gdc_pkg;

  localparam int unsigned GDC_SYNC_STAGES     = 2;
  localparam int unsigned GDC_DEB_CYCLES_DFLT = 16;
  localparam int unsigned GDC_FLT_CYCLES_DFLT = 64;
  localparam int unsigned GDC_STK_CYCLES_DFLT = 4096;

  // Door FSM state encoding, shared with the controller proper
  typedef enum logic [2:0] {
    GDC_ST_CLOSED  = 3'd0,
    GDC_ST_OPENING = 3'd1,
    GDC_ST_OPEN    = 3'd2,
    GDC_ST_CLOSING = 3'd3,
    GDC_ST_STOPPED = 3'd4
  } gdc_state_t;

endpackage

// File: rtl/gdc_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
// The level flips only after DEB_CYCLES consecutive cycles of disagreement.
module gdc_debounce
  import gdc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = GDC_DEB_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [GDC_SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic                       r_level;
  logic                       w_level_nxt;
  logic                       w_sync;

  assign w_sync    = r_sync[GDC_SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign o_level   = r_level;

  // Synchroniser shift chain for the asynchronous raw input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[GDC_SYNC_STAGES-2:0], i_raw};
  end

  // Count disagreement cycles; flip the level when the run reaches DEB_CYCLES
  always_comb begin
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    if (w_sync != r_level) begin
      if (w_cnt_inc == CNT_W'(DEB_CYCLES)) w_level_nxt = w_sync;
      else                                 w_cnt_nxt   = w_cnt_inc;
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

endmodule

// File: rtl/gdc_input_conditioner.sv
// Input conditioner for the garage-door FSM: debounces the button and both
// limit switches, turns a press into a one-cycle activate pulse and raises a
// sticky fault when both limits read closed for too long.
// Optional: define GDC_STUCK_BTN_EN to add the btn_stuck detector and port.
module gdc_input_conditioner
  import gdc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = GDC_DEB_CYCLES_DFLT,
`ifdef GDC_STUCK_BTN_EN
  parameter int unsigned STUCK_CYCLES = GDC_STK_CYCLES_DFLT,
`endif
  parameter int unsigned FAULT_CYCLES = GDC_FLT_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic act_raw,
  input  logic up_max_raw,
  input  logic dn_max_raw,
  input  logic fault_clr,
  output logic activate,
  output logic up_max,
  output logic dn_max,
`ifdef GDC_STUCK_BTN_EN
  output logic btn_stuck,
`endif
  output logic sw_fault
);

  localparam int unsigned FLT_W = $clog2(FAULT_CYCLES + 1);

  logic             w_btn_lvl;
  logic             w_up_lvl;
  logic             w_dn_lvl;
  logic             w_both;
  logic             w_suppress;
  logic             w_act_nxt;
  logic             r_btn_prev;
  logic             r_act;
  logic [FLT_W-1:0] r_fault_cnt;
  logic [FLT_W-1:0] w_fault_cnt_nxt;
  logic             r_sw_fault;
  logic             w_sw_fault_nxt;

  gdc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (act_raw),
    .o_level (w_btn_lvl)
  );

  gdc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (up_max_raw),
    .o_level (w_up_lvl)
  );

  gdc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (dn_max_raw),
    .o_level (w_dn_lvl)
  );

  assign w_both = w_up_lvl & w_dn_lvl;

`ifdef GDC_STUCK_BTN_EN
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] r_stuck_cnt;
  logic [STK_W-1:0] w_stuck_cnt_nxt;
  logic             r_btn_stuck;
  logic             w_btn_stuck_nxt;

  // Saturating hold counter; released button clears the stuck flag
  always_comb begin
    w_stuck_cnt_nxt = '0;
    w_btn_stuck_nxt = 1'b0;
    if (w_btn_lvl) begin
      w_stuck_cnt_nxt = (r_stuck_cnt == STK_W'(STUCK_CYCLES)) ? r_stuck_cnt
                                                              : r_stuck_cnt + STK_W'(1);
      w_btn_stuck_nxt = r_btn_stuck | (w_stuck_cnt_nxt == STK_W'(STUCK_CYCLES));
    end
  end

  // Stuck-button registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stuck_cnt <= '0;
      r_btn_stuck <= 1'b0;
    end else begin
      r_stuck_cnt <= w_stuck_cnt_nxt;
      r_btn_stuck <= w_btn_stuck_nxt;
    end
  end

  assign btn_stuck  = r_btn_stuck;
  assign w_suppress = r_sw_fault | r_btn_stuck;
`else
  assign w_suppress = r_sw_fault;
`endif

  // Rising edge of the debounced button; suppressed presses are dropped, not queued
  assign w_act_nxt = w_btn_lvl & ~r_btn_prev & ~w_suppress;

  // Both-limits run counter and sticky fault; a set always beats a clear
  always_comb begin
    w_fault_cnt_nxt = '0;
    w_sw_fault_nxt  = r_sw_fault;
    if (w_both) begin
      w_fault_cnt_nxt = (r_fault_cnt == FLT_W'(FAULT_CYCLES)) ? r_fault_cnt
                                                              : r_fault_cnt + FLT_W'(1);
      if (w_fault_cnt_nxt == FLT_W'(FAULT_CYCLES)) w_sw_fault_nxt = 1'b1;
    end else if (fault_clr) begin
      w_sw_fault_nxt = 1'b0;
    end
  end

  // Edge-detect, pulse and fault registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_prev  <= 1'b0;
      r_act       <= 1'b0;
      r_fault_cnt <= '0;
      r_sw_fault  <= 1'b0;
    end else begin
      r_btn_prev  <= w_btn_lvl;
      r_act       <= w_act_nxt;
      r_fault_cnt <= w_fault_cnt_nxt;
      r_sw_fault  <= w_sw_fault_nxt;
    end
  end

  assign activate = r_act;
  assign up_max   = w_up_lvl;
  assign dn_max   = w_dn_lvl;
  assign sw_fault = r_sw_fault;

endmodule

// File: tb/tb_gdc_input_conditioner.sv
// Self-checking bench for gdc_input_conditioner (DEB=4, FAULT=8, STUCK=32).
// Define GDC_STUCK_BTN_EN to exercise the stuck-button option as well.
module tb_gdc_input_conditioner;

  localparam int DEB = 4;
  localparam int FLT = 8;
  localparam int STK = 32;

  logic clk;
  logic rst;
  logic act_raw;
  logic up_max_raw;
  logic dn_max_raw;
  logic fault_clr;
  logic activate;
  logic up_max;
  logic dn_max;
  logic sw_fault;
`ifdef GDC_STUCK_BTN_EN
  logic btn_stuck;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gdc_input_conditioner #(
    .DEB_CYCLES   (DEB),
`ifdef GDC_STUCK_BTN_EN
    .STUCK_CYCLES (STK),
`endif
    .FAULT_CYCLES (FLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .act_raw    (act_raw),
    .up_max_raw (up_max_raw),
    .dn_max_raw (dn_max_raw),
    .fault_clr  (fault_clr),
    .activate   (activate),
    .up_max     (up_max),
    .dn_max     (dn_max),
`ifdef GDC_STUCK_BTN_EN
    .btn_stuck  (btn_stuck),
`endif
    .sw_fault   (sw_fault)
  );

  // Reference model: a level flips once the last DEB synchronised samples
  // (raw samples two to DEB+1 edges old) all disagree with it.
  wire [2:0] raw_in = {dn_max_raw, up_max_raw, act_raw};
  logic [DEB:0] m_hist [3];
  logic [2:0]   m_lvl;
  logic         m_act, m_btn_d, m_fault, m_stuck;
  int           m_frun, m_srun;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) m_hist[i] <= '0;
      m_lvl   <= '0;
      m_act   <= 1'b0;
      m_btn_d <= 1'b0;
      m_fault <= 1'b0;
      m_stuck <= 1'b0;
      m_frun  <= 0;
      m_srun  <= 0;
    end else begin
      m_act   <= m_lvl[0] & ~m_btn_d & ~m_fault & ~m_stuck;
      m_btn_d <= m_lvl[0];
      for (int i = 0; i < 3; i++) begin
        m_hist[i] <= {m_hist[i][DEB-1:0], raw_in[i]};
        if (m_lvl[i] ? (m_hist[i][DEB:1] == '0) : (&m_hist[i][DEB:1]))
          m_lvl[i] <= ~m_lvl[i];
      end
      if (m_lvl[1] && m_lvl[2]) begin
        m_frun <= (m_frun >= FLT) ? FLT : m_frun + 1;
        if (m_frun + 1 >= FLT) m_fault <= 1'b1;
      end else begin
        m_frun <= 0;
        if (fault_clr) m_fault <= 1'b0;
      end
`ifdef GDC_STUCK_BTN_EN
      if (m_lvl[0]) begin
        m_srun <= (m_srun >= STK) ? STK : m_srun + 1;
        if (m_srun + 1 >= STK) m_stuck <= 1'b1;
      end else begin
        m_srun  <= 0;
        m_stuck <= 1'b0;
      end
`endif
    end
  end

  task automatic test_reset();
    logic [3:0] g;
    rst = 1'b0; act_raw = 1'b0; up_max_raw = 1'b0; dn_max_raw = 1'b0; fault_clr = 1'b0;
    #12;
    g = {activate, up_max, dn_max, sw_fault};
    n_checks++;
    if (g !== 4'b0000) $display("FAIL reset_hold: got %b, expected 0000", g);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    g = {activate, up_max, dn_max, sw_fault};
    n_checks++;
    if (g !== 4'b0000) $display("FAIL reset_first_cycle: got %b, expected 0000", g);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [3:0] g, e;
    int pulses = 0;
    act_raw = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL glitch j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (activate) pulses++;
      if (j == 2) act_raw = 1'b0;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL glitch_pulses: got %0d, expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_press();
    logic [3:0] g, e;
    int pulses = 0;
    int first_j = -1;
    act_raw = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL press j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (activate === 1'b1) begin
        pulses++;
        if (first_j < 0) first_j = j;
      end
      if (j == 19) act_raw = 1'b0;
    end
    n_checks++;
    if (pulses != 1 || first_j != 6)
      $display("FAIL press_pulse: got %0d pulses at edge +%0d, expected 1 at +6", pulses, first_j);
    else n_pass++;
  endtask

  task automatic test_limit();
    logic [3:0] g, e;
    dn_max_raw = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL limit j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (j == 4 || j == 5 || j == 25) begin
        n_checks++;
        if (dn_max !== (j != 4)) $display("FAIL dn_timing j=%0d: got %b, expected %b", j, dn_max, j != 4);
        else n_pass++;
      end
      if (j == 12) dn_max_raw = 1'b0;
      if (j == 14) dn_max_raw = 1'b1;
      if (j == 28) dn_max_raw = 1'b0;
    end
  endtask

  task automatic test_fault();
    logic [3:0] g, e;
    int pulses = 0;
    up_max_raw = 1'b1; dn_max_raw = 1'b1;
    for (int j = 0; j < 85; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL fault j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (activate === 1'b1) pulses++;
      if (j == 12 || j == 13 || j == 48 || j == 61) begin
        n_checks++;
        if (sw_fault !== (j == 13 || j == 48))
          $display("FAIL fault_timing j=%0d: got %b, expected %b", j, sw_fault, j == 13 || j == 48);
        else n_pass++;
      end
      case (j)
        20: act_raw = 1'b1;
        35: act_raw = 1'b0;
        45: fault_clr = 1'b1;
        46: fault_clr = 1'b0;
        50: up_max_raw = 1'b0;
        60: fault_clr = 1'b1;
        61: fault_clr = 1'b0;
        70: dn_max_raw = 1'b0;
        default: ;
      endcase
    end
    n_checks++;
    if (pulses != 0) $display("FAIL fault_suppress: got %0d pulses, expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] g, e;
    int pulses = 0;
    int first_j = -1;
    act_raw = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL pre_reset j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
    end
    #2 rst = 1'b0;
    #1;
    g = {activate, up_max, dn_max, sw_fault};
`ifdef GDC_STUCK_BTN_EN
    g[3] = g[3] | btn_stuck;
`endif
    n_checks++;
    if (g !== 4'b0000) $display("FAIL reset_async: got %b, expected 0000", g);
    else n_pass++;
    @(negedge clk); rst = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault};
      n_checks++;
      if (g !== e) $display("FAIL post_reset j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (activate === 1'b1) begin
        pulses++;
        if (first_j < 0) first_j = j;
      end
    end
    n_checks++;
    if (pulses != 1 || first_j != 6)
      $display("FAIL reset_held_pulse: got %0d pulses at edge +%0d, expected 1 at +6", pulses, first_j);
    else n_pass++;
    act_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

`ifdef GDC_STUCK_BTN_EN
  task automatic test_stuck();
    logic [4:0] g, e;
    act_raw = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault, btn_stuck};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault, m_stuck};
      n_checks++;
      if (g !== e) $display("FAIL stuck j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if (j == 36 || j == 37 || j == 50 || j == 51) begin
        n_checks++;
        if (btn_stuck !== (j == 37 || j == 50))
          $display("FAIL stuck_timing j=%0d: got %b, expected %b", j, btn_stuck, j == 37 || j == 50);
        else n_pass++;
      end
      if (j == 44) act_raw = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] g, e;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      g = {activate, up_max, dn_max, sw_fault, 1'b0};
      e = {m_act, m_lvl[1], m_lvl[2], m_fault, 1'b0};
`ifdef GDC_STUCK_BTN_EN
      g[0] = btn_stuck;
      e[0] = m_stuck;
`endif
      n_checks++;
      if (g !== e) $display("FAIL random j=%0d: got %b, expected %b", j, g, e);
      else n_pass++;
      if ($urandom_range(9, 0) == 0)  act_raw    = ~act_raw;
      if ($urandom_range(13, 0) == 0) up_max_raw = ~up_max_raw;
      if ($urandom_range(13, 0) == 0) dn_max_raw = ~dn_max_raw;
      fault_clr = ($urandom_range(7, 0) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_limit();
    test_fault();
    test_reset_mid();
`ifdef GDC_STUCK_BTN_EN
    test_stuck();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gdc_input_conditioner.md
Name: gdc_input_conditioner

Overview:
- Front-end stage for the garage-door controller FSM.
- Takes the raw push-button and the two raw limit switches, synchronises and debounces them, and drives the FSM's activate, up_max and dn_max inputs.
- Converts the button press into a single-cycle activate pulse.
- Flags an inconsistent limit-switch condition (both limits closed).

Parameters:
- DEB_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced level before that level flips; must be >= 2.
- FAULT_CYCLES, 64: consecutive cycles both debounced limits must be high before sw_fault sets; must be >= 1.
- STUCK_CYCLES, 4096: only used with GDC_STUCK_BTN_EN; cycles of continuous debounced press before btn_stuck sets.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- act_raw, in, 1: raw push-button, asynchronous, active-high.
- up_max_raw, in, 1: raw upper limit switch, asynchronous, active-high.
- dn_max_raw, in, 1: raw lower limit switch, asynchronous, active-high.
- fault_clr, in, 1: synchronous request to clear sw_fault.
- activate, out, 1: one-cycle pulse per debounced button press.
- up_max, out, 1: debounced upper limit level.
- dn_max, out, 1: debounced lower limit level.
- sw_fault, out, 1: sticky limit-switch fault.
- btn_stuck, out, 1: only with GDC_STUCK_BTN_EN.

Behaviour:
- Reset: rst low asynchronously clears everything.
  - Cleared state: synchroniser flops, debounced levels, counters, edge-detect register, sw_fault and btn_stuck all go to 0.
  - Outputs read 0 during reset and on the first cycle after release.
- Synchroniser: each raw input passes through 2 flops; the value sampled at edge k appears at the sync output at edge k+1.
- Debounce, per input, independent:
  - Counter clears whenever sync == debounced level.
  - Otherwise it increments each cycle.
  - When the counter would reach DEB_CYCLES, the debounced level takes the sync value and the counter clears.
  - Counter width is clog2(DEB_CYCLES+1) bits and never wraps.
- Latency: raw level held from sampling edge k -> debounced level changes at edge k+1+DEB_CYCLES.
- Glitch rejection: any raw excursion shorter than DEB_CYCLES cycles produces no output change.
- up_max and dn_max: registered debounced levels, driven directly.
- activate:
  - High for exactly 1 cycle, on the cycle after the debounced button level goes 0->1.
  - Held or released buttons produce no further pulses.
  - A button held through reset release yields one pulse once debounced.
- Fault detection:
  - A fault counter increments while debounced up_max and dn_max are both 1, and clears otherwise.
  - At FAULT_CYCLES the counter saturates and sw_fault sets.
  - sw_fault is sticky.
  - fault_clr clears sw_fault only when the both-high condition is absent that cycle.
  - If set and clear occur in the same cycle, set wins.
- While sw_fault = 1:
  - activate pulses are suppressed.
  - up_max and dn_max still report their debounced levels.
- Debounced button events that occur during suppression are consumed; they are not replayed after the clear.

Optional Feature:
- GDC_STUCK_BTN_EN defined:
  - btn_stuck port exists.
  - A stuck counter runs while the debounced button is 1 and saturates at STUCK_CYCLES, which sets btn_stuck.
  - btn_stuck clears on the first cycle the debounced button is 0.
  - activate is suppressed while btn_stuck = 1.
- GDC_STUCK_BTN_EN undefined: no btn_stuck port and no stuck counter; behaviour is otherwise identical.

Decomposition:
- Shared package gdc_pkg holds: GDC_SYNC_STAGES = 2, default debounce/fault/stuck cycle constants, and the gdc_state_t encoding shared with the door FSM.
- Sub-module gdc_debounce: synchroniser + debounce counter + level register, parameterised by DEB_CYCLES, instantiated 3 times.

Test Plan (DEB_CYCLES = 4, FAULT_CYCLES = 8, STUCK_CYCLES = 32):
- act_raw high for 3 cycles then low -> activate never asserts; debounced level stays 0.
- act_raw rises and is held 20 cycles -> activate high for exactly 1 cycle, 6 edges after the first sampling edge; no second pulse on release.
- dn_max_raw held high -> dn_max goes 1 at edge k+5; dn_max_raw dropped for 2 cycles -> dn_max stays 1.
- Both limits held high 20 cycles -> sw_fault sets 8 cycles after both debounced levels are 1.
  - Button press during the fault -> no activate.
  - fault_clr while both limits are still high -> sw_fault stays 1.
  - Release up_max, then fault_clr -> sw_fault returns to 0.
- Button debounced high, rst pulsed low mid-hold -> all outputs 0 immediately; after release, one activate pulse 6 edges later.
- GDC_STUCK_BTN_EN defined, button held 40 cycles -> btn_stuck = 1 after 32 debounced-high cycles; clears when the debounced level falls.
